// File: rtl/cpu7_mem_arb.sv
// cpu7_mem_arb: single-outstanding arbiter of the fetch and data request ports
// onto one shared SRAM-style memory port. Data wins by default; a starvation
// counter forces a fetch grant after STARVE_LIMIT data grants with a fetch waiting.
module cpu7_mem_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          inst_cancel,
  output logic          inst_addr_ok,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_valid,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_wstrb,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic          data_cancel,
  output logic          data_addr_ok,
  output logic [DW-1:0] data_rdata,
  output logic          data_data_ok,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_data_ok,
  output logic          arb_busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [7:0]      starve_q, starve_d;
  logic            cancel_q, cancel_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_q, mem_wr_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            data_win;
  logic            inst_win;
  logic            owner_cancel;
  logic            resp;

  // Grant decision and response qualification
  always_comb begin
    data_win     = (state_q == S_IDLE) && data_req && !(inst_req && (starve_q == LIMIT));
    inst_win     = (state_q == S_IDLE) && inst_req && !data_win;
    owner_cancel = ((owner_q == OWN_I) && inst_cancel) || ((owner_q == OWN_D) && data_cancel);
    resp         = (state_q == S_WAIT) && mem_data_ok;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      cancel_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      cancel_q    <= cancel_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (data_win || inst_win) state_d = S_REQ;
      S_REQ:   if (mem_addr_ok)          state_d = S_WAIT;
      S_WAIT:  if (mem_data_ok)          state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Grant latching, starvation count and cancel tracking
  always_comb begin
    owner_d     = owner_q;
    starve_d    = starve_q;
    cancel_d    = cancel_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (data_win) begin
      owner_d     = OWN_D;
      mem_req_d   = 1'b1;
      mem_wr_d    = data_wr;
      mem_wstrb_d = data_wr ? data_wstrb : 4'b0000;
      mem_addr_d  = data_addr;
      mem_wdata_d = data_wdata;
      cancel_d    = data_cancel;
      if (inst_req && (starve_q != 8'hFF)) starve_d = starve_q + 8'd1;
    end else if (inst_win) begin
      owner_d     = OWN_I;
      mem_req_d   = 1'b1;
      mem_wr_d    = 1'b0;
      mem_wstrb_d = 4'b0000;
      mem_addr_d  = inst_addr;
      mem_wdata_d = '0;
      cancel_d    = inst_cancel;
      starve_d    = '0;
    end
    if ((state_q == S_REQ) && mem_addr_ok) mem_req_d = 1'b0;
    if ((state_q != S_IDLE) && owner_cancel) cancel_d = 1'b1;
    if (resp) begin
      cancel_d = 1'b0;
      owner_d  = OWN_NONE;
    end
  end

  // Outputs; a cancel arriving with the response also suppresses it
  always_comb begin
    inst_addr_ok = inst_win;
    data_addr_ok = data_win;
    arb_busy     = (state_q != S_IDLE);
    inst_valid   = resp && (owner_q == OWN_I) && !(cancel_q || owner_cancel);
    data_data_ok = resp && (owner_q == OWN_D) && !(cancel_q || owner_cancel);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    mem_req      = mem_req_q;
    mem_wr       = mem_wr_q;
    mem_wstrb    = mem_wstrb_q;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
  end

endmodule
